mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  qualifies mdOp for one cycle.
REQ-006 SHALL have port mdOp  input  3  operation code (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-007 SHALL have port A  input  32  rs operand (dividend/multiplicand; MTHI/MTLO data).
REQ-008 SHALL have port B  input  32  rt operand (divisor/multiplier).
REQ-009 SHALL have port busy  output  1  registered; high while a mult/div is in flight.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.

Function
REQ-012 SHALL implement states IDLE and BUSY plus a down-counter cnt.
REQ-013 SHALL, in IDLE with start=1 and mdOp in {MULT, MULTU, DIV, DIVU}, latch the result into pending HI/LO, load cnt with MULT_CYCLES or DIV_CYCLES, and enter BUSY next edge.
REQ-014 SHALL assert busy for exactly N consecutive cycles starting the cycle after start (N = MULT_CYCLES or DIV_CYCLES).
REQ-015 SHALL decrement cnt each cycle in BUSY; at cnt=1, commit pending HI/LO to HI/LO and return to IDLE; new HI/LO visible the same cycle busy falls.
REQ-016 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned; HI = bits 63:32, LO = bits 31:0.
REQ-017 SHALL compute DIV as signed (LO = quotient truncated toward zero, HI = remainder with dividend sign) and DIVU as unsigned.
REQ-018 SHALL, on DIV/DIVU with B=0, still run DIV_CYCLES busy cycles and leave HI/LO unchanged.
REQ-019 SHALL, on MTHI/MTLO with start=1 in IDLE, write A to HI/LO at the next edge with no busy cycles.
REQ-020 SHALL ignore start (any mdOp) while in BUSY; the hazard unit guarantees no issue during busy.
REQ-021 SHALL treat mdOp=NONE or start=0 as no-op.
REQ-022 SHALL keep HI/LO stable during BUSY; reads during busy return the pre-operation values.

Reset
REQ-023 SHALL, on reset=0 at any time including mid-operation, asynchronously force state=IDLE, cnt=0, busy=0, HI=0, LO=0, pending=0.
REQ-024 SHALL accept start on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL support macro MDU_CANCEL_EN: when defined, adds input cancel (1 bit); cancel=1 in BUSY returns to IDLE next edge, busy=0, HI/LO unchanged (exception flush of the in-flight op).
REQ-026 SHALL, without MDU_CANCEL_EN, have no cancel port; every started op runs to completion.

Structure
REQ-027 SHALL take mdOp encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6) and state encodings from the shared definitions header used by the control and stall logic.
REQ-028 SHALL be one flat module; no sub-module is natural (arithmetic is single-expression, control is a two-state FSM with counter).

Verification
REQ-029 SHALL test MULT A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 SHALL test DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU same operands -> LO=0x7FFFFFFC, HI=1.
REQ-031 SHALL test DIVU B=0 after MTHI 0x1234/MTLO 0x5678 -> busy 10 cycles, HI=0x1234, LO=0x5678 afterwards.
REQ-032 SHALL test start=1 MTLO 0xAAAA during MULT busy -> ignored; LO gets only the MULT result.
REQ-033 SHALL test reset=0 at busy cycle 3 of DIVU -> busy=0, HI=LO=0 immediately, no later commit.
REQ-034 SHALL test, with MDU_CANCEL_EN, cancel at busy cycle 2 of MULTU -> busy=0 next edge, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation codes and FSM state encodings used by
// the MDU and by the control/stall logic that issues into it.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO. Results are computed at issue
// and committed after a fixed busy latency. Optional macro: MDU_CANCEL_EN.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output mdu_state_e  dbg_state
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Handshake: start is a one-cycle strobe qualifying mdOp/A/B; it is only
  // honoured while busy is low, and results appear in HI/LO when busy falls.

  mdu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy_q, busy_nxt;
  logic [31:0]      hi_q, hi_nxt, lo_q, lo_nxt;
  logic [31:0]      pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;

  logic [63:0] prod_s, prod_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        b_zero;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign b_zero = (B == 32'd0);
  // Divider outputs are only consumed when B is nonzero.
  assign quo_s  = $signed(A) / $signed(B);
  assign rem_s  = $signed(A) % $signed(B);
  assign quo_u  = A / B;
  assign rem_u  = A % B;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    busy_nxt    = busy_q;
    hi_nxt      = hi_q;
    lo_nxt      = lo_q;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    if (state == ST_IDLE) begin
      if (start) begin
        case (md_op_e'(mdOp))
          MD_MULT, MD_MULTU: begin
            {pend_hi_nxt, pend_lo_nxt} = (md_op_e'(mdOp) == MD_MULT) ? prod_s : prod_u;
            cnt_nxt   = CNT_W'(MULT_CYCLES);
            state_nxt = ST_BUSY;
            busy_nxt  = 1'b1;
          end
          MD_DIV, MD_DIVU: begin
            // Divide by zero still occupies the unit but commits the old HI/LO.
            if (b_zero) begin
              pend_hi_nxt = hi_q;
              pend_lo_nxt = lo_q;
            end else if (md_op_e'(mdOp) == MD_DIV) begin
              pend_hi_nxt = rem_s;
              pend_lo_nxt = quo_s;
            end else begin
              pend_hi_nxt = rem_u;
              pend_lo_nxt = quo_u;
            end
            cnt_nxt   = CNT_W'(DIV_CYCLES);
            state_nxt = ST_BUSY;
            busy_nxt  = 1'b1;
          end
          MD_MTHI: hi_nxt = A;
          MD_MTLO: lo_nxt = A;
          default: ;
        endcase
      end
    end else begin
`ifdef MDU_CANCEL_EN
      if (cancel) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end else
`endif
      if (cnt == CNT_W'(1)) begin
        hi_nxt    = pend_hi;
        lo_nxt    = pend_lo;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busy_q  <= busy_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
    end
  end

  assign busy      = busy_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign dbg_state = state;

endmodule
